// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a write to 0xFF46 copies 160 bytes from {page,00..9F} into 0xFE00..0xFE9F,
// taking the memory port from the CPU for the length of the transfer.
module oam_dma_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy,
  output logic [7:0]  dma_page,
  output logic        cpu_blocked
);

  typedef enum logic [1:0] {IDLE, SETUP, READ, WRITE} state_t;

  state_t     state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] byte_buf;
  logic [7:0] src_page;
  logic       trigger;
  logic       dma_active;

  assign trigger    = cpu_we && (cpu_addr == 16'hFF46);
  assign dma_active = (state == READ) || (state == WRITE);
  // Pages E0..FF are echo RAM and alias onto C0..DF.
  assign src_page   = (dma_page >= 8'hE0) ? (dma_page - 8'h20) : dma_page;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 8'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_buf <= 8'h00;
      dma_page <= 8'h00;
    end else begin
      if (trigger)
        dma_page <= cpu_wdata;
      if (state == READ)
        byte_buf <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    dma_busy    = (state != IDLE);
    cpu_blocked = 1'b0;
    cpu_rdata   = mem_rdata;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    mem_re      = cpu_re;
    mem_we      = cpu_we;

    case (state)
      IDLE: begin
        if (trigger)
          state_nxt = SETUP;
      end
      SETUP: begin
        if (!trigger) begin
          state_nxt = READ;
          idx_nxt   = 8'h00;
        end
      end
      READ: begin
        if (trigger) begin
          state_nxt = SETUP;
          idx_nxt   = 8'h00;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (trigger) begin
          state_nxt = SETUP;
          idx_nxt   = 8'h00;
        end else if (idx < 8'd159) begin
          state_nxt = READ;
          idx_nxt   = idx + 8'd1;
        end else begin
          state_nxt = IDLE;
          idx_nxt   = 8'h00;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 8'h00;
      end
    endcase

    // While the engine owns the bus, the CPU sees 0xFF and only the page register accepts writes.
    if (dma_active) begin
      cpu_rdata   = 8'hFF;
      cpu_blocked = !trigger && (cpu_re || cpu_we);
    end

    if (state == READ) begin
      mem_addr  = {src_page, idx};
      mem_re    = 1'b1;
      mem_we    = 1'b0;
      mem_wdata = byte_buf;
    end else if (state == WRITE) begin
      mem_addr  = 16'hFE00 + {8'h00, idx};
      mem_re    = 1'b0;
      mem_we    = !trigger;
      mem_wdata = byte_buf;
    end
  end

endmodule

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port cpu_addr, input, 16 bits: CPU address.
REQ-004 SHALL have port cpu_wdata, input, 8 bits: CPU write data.
REQ-005 SHALL have ports cpu_re and cpu_we, input, 1 bit each: CPU read and write strobes.
REQ-006 SHALL have port cpu_rdata, output, 8 bits: read data returned to the CPU.
REQ-007 SHALL have ports mem_addr (output, 16 bits) and mem_wdata (output, 8 bits): memory-unit address and write data.
REQ-008 SHALL have ports mem_re and mem_we, output, 1 bit each: memory-unit read and write strobes.
REQ-009 SHALL have port mem_rdata, input, 8 bits: memory-unit read data, valid in the same cycle as mem_re.
REQ-010 SHALL have port dma_busy, output, 1 bit: a DMA transfer is in progress.
REQ-011 SHALL have port dma_page, output, 8 bits: last value written to 0xFF46, for control-register readback.
REQ-012 SHALL have port cpu_blocked, output, 1 bit: one-cycle pulse when a CPU access is refused.

Function
REQ-013 SHALL define a trigger as a clock edge at which cpu_we=1 and cpu_addr=0xFF46; on a trigger, cpu_wdata SHALL be latched into dma_page.
REQ-014 SHALL implement the states IDLE, SETUP, READ and WRITE, with a byte index idx of 8 bits in the range 0..159.
REQ-015 SHALL make these transitions:
- IDLE to SETUP on a trigger.
- SETUP to READ, with idx=0.
- READ to WRITE.
- WRITE to READ with idx+1 when idx<159.
- WRITE to IDLE when idx=159.
REQ-016 SHALL drive dma_busy=1 in SETUP, READ and WRITE; a transfer SHALL keep dma_busy high for exactly 321 cycles, starting the cycle after the trigger edge.
REQ-017 SHALL form the source address in READ as {src_page, idx}, where src_page = dma_page − 0x20 when dma_page ≥ 0xE0 and src_page = dma_page otherwise.
REQ-018 SHALL, in READ, drive mem_re=1, mem_we=0 and mem_addr=source address, and capture mem_rdata into an 8-bit byte buffer at the end of the cycle.
REQ-019 SHALL, in WRITE, drive mem_we=1, mem_re=0, mem_addr=0xFE00+idx and mem_wdata=byte buffer.
REQ-020 SHALL, in IDLE and SETUP, pass the CPU through to memory: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_re=cpu_re, mem_we=cpu_we, cpu_rdata=mem_rdata.
REQ-021 SHALL, in READ and WRITE, treat CPU accesses as follows:
- A CPU read SHALL return cpu_rdata=0xFF.
- A CPU write to any address other than 0xFF46 SHALL be dropped.
- For either refused access, cpu_blocked=1 SHALL be asserted for that cycle.
REQ-022 SHALL, on a trigger during READ or WRITE, latch the new page, not assert cpu_blocked, and go to SETUP, restarting from idx=0; the in-flight byte SHALL be abandoned with no WRITE issued for it.
REQ-023 SHALL, on a trigger in SETUP, latch the new page and stay in SETUP for one more cycle.
REQ-024 SHALL NOT assert mem_re and mem_we in the same cycle.
REQ-025 SHALL keep idx arithmetic 8-bit and never let it exceed 159; the address add 0xFE00+idx SHALL be 16-bit with no carry beyond 0xFE9F.

Reset
REQ-026 SHALL, while rst=0, asynchronously force:
- state=IDLE, idx=0, byte buffer=0x00;
- dma_page=0x00, dma_busy=0, cpu_blocked=0.
REQ-027 SHALL, when rst is asserted mid-transfer, abort the transfer immediately; no further DMA mem_we SHALL occur, and pass-through SHALL resume on the first edge after rst returns to 1.
REQ-028 SHALL, during reset, drive the mem_* outputs as the CPU pass-through combination of REQ-020.

Verification
REQ-029 SHALL cover a basic copy:
- Stimulus: memory 0xC000..0xC09F preloaded with i^0x5A; CPU writes 0xC0 to 0xFF46.
- Response: dma_busy high for 321 cycles; FE00+i = i^0x5A for all i; exactly 160 mem_we pulses; dma_page=0xC0.
REQ-030 SHALL cover echo mapping: a write of 0xE1 to 0xFF46 reads from 0xC100..0xC19F, and dma_page reads back 0xE1.
REQ-031 SHALL cover CPU blocking: during a transfer, a CPU read of 0xC000 returns 0xFF and a CPU write of 0x33 to 0xD000 leaves 0xD000 unchanged, each with a one-cycle cpu_blocked pulse.
REQ-032 SHALL cover restart: writing 0xD0 to 0xFF46 at idx=50 makes the next READ address 0xD000; the final OAM holds the 0xD0xx data; dma_busy stays high continuously through the restart.
REQ-033 SHALL cover reset mid-transfer: rst=0 at idx=80 drives dma_busy=0 asynchronously with no further DMA writes; after release, a CPU write passes through to memory unchanged.
REQ-034 SHALL cover the boundary: the last WRITE targets 0xFE9F, and the cycle after it is IDLE, with the CPU read of 0xC000 returning true memory data.
